ex_muldiv: RTL
==============

# ex_muldiv

Multi-cycle RV32M multiply/divide unit in the execute stage. It takes operands and the destination register from the ID/EX pipeline register outputs. It produces a 32-bit result plus the destination register, and requests a pipeline stall while it is busy. The EX/MEM writeback path merges its result on `done`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous reset, active-low (0 = reset), sampled on the rising edge of `clk`.
- `start`, in, 1: request a new operation; sampled only in IDLE.
- `op`, in, 3: RV32M funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `opa`, in, 32: rs1 value (multiplicand / dividend).
- `opb`, in, 32: rs2 value (multiplier / divisor).
- `wd_in`, in, 5: destination register address.
- `flush`, in, 1: abort any in-flight operation (branch mispredict / exception).
- `stall_req`, out, 1: stall request to the pipeline control.
- `done`, out, 1: single-cycle pulse; `result` and `wd_out` are valid.
- `result`, out, 32: operation result, held until the next accepted `start`.
- `wd_out`, out, 5: destination register latched at `start`.

## Operation
- States:
  - IDLE: waiting for `start`.
  - MUL: one-cycle product computation.
  - DIV: iterative divide.
  - FIN: output cycle; `done`=1.
- IDLE with `start`=1 and `flush`=0 accepts the operation. It latches `op`, `opa`, `opb` and `wd_in`, then:
  - MUL ops go to MUL.
  - Divide ops with `opb`=0 go directly to FIN with the special result.
  - DIV/REM with `opa`=0x80000000 and `opb`=0xFFFFFFFF go directly to FIN with the special result.
  - All other divide ops go to DIV, with the iteration counter set to 0.
- MUL:
  - Form the 64-bit product with operand signedness per op: MULH s×s, MULHSU s×u, MULHU u×u.
  - MUL selects product[31:0]; the others select product[63:32]. Then go to FIN.
- DIV:
  - Unsigned restoring division on the magnitudes: |a| for DIV/REM, raw values for DIVU/REMU.
  - One quotient bit per cycle for 32 cycles; the 6-bit counter runs 0..31. Go to FIN after iteration 31.
  - Sign fix-up on the FIN transition:
    - Quotient is negated if the signs of `opa` and `opb` differ (signed ops only).
    - Remainder takes the sign of `opa`.
- Special results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = `opa`.
  - Overflow: DIV = 0x80000000; REM = 0.
- FIN: drives `done`=1 for one cycle, then returns to IDLE. `start` in FIN is ignored; the pipeline re-presents it.
- `start` while not in IDLE is ignored.
- `flush`=1 in any state:
  - Return to IDLE on the next edge and do not assert `done`.
  - `result` and `wd_out` keep their previous values.
  - `flush` has priority over `start`.
- `stall_req` (combinational) = (state==IDLE && `start` && !`flush`) || state==MUL || state==DIV. It is 0 in FIN and IDLE otherwise.

## Timing
- Reset (`rst`=0 at an edge):
  - state=IDLE, counter=0.
  - `done`=0, `result`=0x00000000, `wd_out`=5'b00000.
  - `stall_req` follows its equation with state=IDLE.
- Reset overrides `start` and `flush`; an operation in progress is discarded.
- Latency, counting edges after the accepting edge E0:
  - MUL*: `done` high in the cycle after E1 (2-cycle occupancy).
  - Special divide: `done` after E1.
  - Normal divide: `done` after E33 (32 iterations plus the FIN transition).
- `done` is high for exactly one cycle. `result` changes only on the edge entering FIN, or on reset.
- Back-to-back: a new `start` is accepted in the IDLE cycle following FIN; there are no bubbles beyond that.

## Test plan
- MUL: `opa`=7, `opb`=0xFFFFFFFD -> `done` one cycle after accept, `result`=0xFFFFFFEB; `stall_req` high in the start cycle and the MUL cycle only.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF -> `result`=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU: `opa`=0xFFFFFFFF, `opb`=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD with `done` exactly 33 edges after accept; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each completes with `done` one cycle after accept.
- Flush: start DIV with `wd_in`=5, flush at iteration 10 -> IDLE, no `done`, `stall_req`=0, `result` and `wd_out` unchanged. A following DIVU 9/3 -> 3.
- Reset: pull `rst` low mid-divide -> next cycle all outputs at reset values, and a `start` pulsed during reset is not accepted.

Source files
------------

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the execute stage: a single-cycle multiply
// and a 32-step restoring divider. It raises stall_req while busy.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      wd_in,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wd_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      CNT_FIX = 6'd32;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      wd_q;
  logic [5:0]      cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            neg_quo_q, neg_rem_q;
  logic            spec_q;
  logic [XLEN-1:0] spec_res_q;

  // Decode of the incoming operation at accept time.
  logic            in_sgn, in_rem, in_bzero, in_ovf, in_spec;
  logic [XLEN-1:0] in_abs_a, in_abs_b, in_spec_val;

  always_comb begin
    in_sgn      = ~op[0];
    in_rem      = op[1];
    in_bzero    = (opb == '0);
    in_ovf      = in_sgn && (opa == MIN_NEG) && (opb == '1);
    in_spec     = in_bzero || in_ovf;
    in_abs_a    = (in_sgn && opa[XLEN-1]) ? (~opa + 1'b1) : opa;
    in_abs_b    = (in_sgn && opb[XLEN-1]) ? (~opb + 1'b1) : opb;
    in_spec_val = '0;
    if (in_bzero)
      in_spec_val = in_rem ? opa : '1;
    else
      in_spec_val = in_rem ? '0 : MIN_NEG;
  end

  // Multiply datapath, using the latched operands.
  logic                   a_signed, b_signed;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0]        mul_res;

  always_comb begin
    a_signed = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
    b_signed = (op_q[1:0] == 2'b01);
    mul_a    = {a_signed & a_q[XLEN-1], a_q};
    mul_b    = {b_signed & b_q[XLEN-1], b_q};
    prod     = mul_a * mul_b;
    mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // One restoring-division step, plus the sign fix-up applied on leaving DIV.
  logic [XLEN:0]   shifted, diff;
  logic            step_ge;
  logic [XLEN-1:0] step_rem, step_quo, quo_fix, rem_fix, div_res;

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    step_ge  = ~diff[XLEN];
    step_rem = step_ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], step_ge};
    quo_fix  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix  = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    div_res  = spec_q ? spec_res_q : (op_q[1] ? rem_fix : quo_fix);
  end

  assign stall_req = ((state == S_IDLE) && start && !flush) ||
                     (state == S_MUL) || (state == S_DIV);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      result     <= '0;
      wd_out     <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wd_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q <= op;
            a_q  <= opa;
            b_q  <= opb;
            wd_q <= wd_in;
            if (!op[2]) begin
              state <= S_MUL;
            end else begin
              // Special cases go through one DIV cycle with the counter preset
              // to the fix-up value, so they finish with the same latency as MUL.
              state      <= S_DIV;
              cnt        <= in_spec ? CNT_FIX : '0;
              rem_q      <= '0;
              quo_q      <= in_abs_a;
              dvs_q      <= in_abs_b;
              neg_quo_q  <= in_sgn && (opa[XLEN-1] ^ opb[XLEN-1]);
              neg_rem_q  <= in_sgn && opa[XLEN-1];
              spec_q     <= in_spec;
              spec_res_q <= in_spec_val;
            end
          end
        end
        S_MUL: begin
          result <= mul_res;
          wd_out <= wd_q;
          done   <= 1'b1;
          state  <= S_FIN;
        end
        S_DIV: begin
          if (cnt == CNT_FIX) begin
            result <= div_res;
            wd_out <= wd_q;
            done   <= 1'b1;
            cnt    <= '0;
            state  <= S_FIN;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt   <= cnt + 6'd1;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
